// File: rtl/serial_cmp_ctrl.sv
// Bit-serial magnitude comparator: walks two latched operands MSB-first through a
// single 1-bit comparator cell and stops at the first differing bit.
module serial_cmp_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             great,
  output logic             less,
  output logic             eq
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [CNT_W-1:0] idx;

  logic bit_a;
  logic bit_b;
  logic cell_great;
  logic cell_less;
  logic cell_eq;

  // The one shared 1-bit comparator cell, fed from the current bit index.
  assign bit_a      = a_r[idx];
  assign bit_b      = b_r[idx];
  assign cell_great = bit_a & ~bit_b;
  assign cell_less  = ~bit_a & bit_b;
  assign cell_eq    = ~(bit_a ^ bit_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      a_r   <= '0;
      b_r   <= '0;
      idx   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      great <= 1'b0;
      less  <= 1'b0;
      eq    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            a_r   <= a_in;
            b_r   <= b_in;
            idx   <= CNT_W'(WIDTH - 1);
            great <= 1'b0;
            less  <= 1'b0;
            eq    <= 1'b0;
            busy  <= 1'b1;
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          // The exit at bit 0 takes priority over the decrement, so idx never wraps.
          if (!cell_eq) begin
            great <= cell_great;
            less  <= cell_less;
            eq    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else if (idx == '0) begin
            eq    <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            idx <= idx - CNT_W'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// Bench for serial_cmp_ctrl: directed scenarios plus randomized compares checked
// against an arithmetic reference for result flags and latency.
module tb_serial_cmp_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic         great;
  logic         less;
  logic         eq;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  serial_cmp_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a_in  (a_in),
    .b_in  (b_in),
    .busy  (busy),
    .done  (done),
    .great (great),
    .less  (less),
    .eq    (eq)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Number of bits examined: stops at the most significant differing bit.
  function automatic int ref_len(input logic [W-1:0] a, input logic [W-1:0] b);
    for (int i = W - 1; i >= 0; i--)
      if (a[i] != b[i]) return W - i;
    return W;
  endfunction

  function automatic logic [2:0] ref_flags(input logic [W-1:0] a, input logic [W-1:0] b);
    return {a > b, a < b, a == b};
  endfunction

  task automatic wait_done(input bit scramble, output int cyc);
    cyc = 0;
    while (cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) break;
      chk("busy_in_shift", busy, 1);
      chk("flags_inflight", {great, less, eq}, 0);
      if (scramble) begin
        a_in = W'($urandom);
        b_in = W'($urandom);
      end
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  task automatic do_cmp(input logic [W-1:0] a, input logic [W-1:0] b, input bit scramble);
    int cyc;
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_accept", busy, 1);
    chk("flags_clear", {great, less, eq}, 0);
    wait_done(scramble, cyc);
    chk("latency", cyc, ref_len(a, b));
    chk("flags", {great, less, eq}, ref_flags(a, b));
    chk("busy_at_done", busy, 0);
    @(posedge clk);
    #1;
    chk("done_pulse", done, 0);
    chk("flags_hold", {great, less, eq}, ref_flags(a, b));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    int nd;
    int dat;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    // Reset and idle
    rst_n = 1'b0;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", {busy, done, great, less, eq}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("idle_outs", {busy, done, great, less, eq}, 0);
    end

    // MSB differs, LSB differs, equal
    do_cmp(8'h80, 8'h7F, 1'b0);
    do_cmp(8'h10, 8'h11, 1'b0);
    do_cmp(8'hA5, 8'hA5, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("eq_held", {busy, done, great, less, eq}, 5'b00001);
    end

    // Ignored start and operand change while busy
    @(negedge clk);
    a_in  = 8'h0F;
    b_in  = 8'h0E;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    nd  = 0;
    dat = 0;
    for (int e = 1; e <= 20 && nd == 0; e++) begin
      if (e > 1) begin
        @(posedge clk);
        #1;
      end
      if (done) begin
        nd++;
        dat = e - 1;
      end
      if (e == 3) begin
        a_in  = 8'hFF;
        b_in  = 8'h00;
        start = 1'b1;
      end else if (e == 4) begin
        start = 1'b0;
        a_in  = 8'h00;
        b_in  = 8'hFF;
      end
    end
    chk("t5_done_at", dat, ref_len(8'h0F, 8'h0E));
    chk("t5_flags", {great, less, eq}, ref_flags(8'h0F, 8'h0E));
    // start held through the done cycle: accepted on the following IDLE edge
    a_in  = 8'h01;
    b_in  = 8'h02;
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_idle_busy", busy, 0);
    chk("t5_idle_done", done, 0);
    chk("t5_idle_flags", {great, less, eq}, 3'b100);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("t5_reaccept_busy", busy, 1);
    chk("t5_reaccept_flags", {great, less, eq}, 0);
    wait_done(1'b0, cyc);
    chk("t5_latency2", cyc - 1, ref_len(8'h01, 8'h02) - 1);
    chk("t5_flags2", {great, less, eq}, ref_flags(8'h01, 8'h02));
    @(posedge clk);
    #1;

    // Reset mid-compare
    @(negedge clk);
    a_in  = 8'h00;
    b_in  = 8'h00;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_busy_drop", busy, 0);
    chk("t6_outs", {done, great, less, eq}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done) nd++;
    end
    chk("t6_no_done", nd, 0);
    chk("t6_flags", {busy, great, less, eq}, 0);
    do_cmp(8'hA5, 8'hA5, 1'b0);

    // Randomized compares with operand scrambling while busy
    for (int n = 0; n < 40; n++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 2))
        0:       rb = W'($urandom);
        1:       rb = ra;
        default: rb = ra ^ (W'(1) << $urandom_range(0, W - 1));
      endcase
      do_cmp(ra, rb, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
